// File: rtl/ram_demux_n.sv
// Routes one read/write request stream to one of NUM_RAMS 1R1W RAMs selected by a sel register.
// Changing sel drains all outstanding read data and write responses before it takes effect.
module ram_demux_n #(
  parameter int DATA_WIDTH     = 64,
  parameter int SIZE           = 128,
  parameter int ADDR_WIDTH     = $clog2(SIZE),
  parameter int NUM_PARTITIONS = 64,
  parameter int NUM_RAMS       = 4,
  parameter int SEL_WIDTH      = $clog2(NUM_RAMS)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [SEL_WIDTH-1:0]                          sel_req_data,
  input  logic                                          sel_req_vld,
  output logic                                          sel_req_rdy,
  output logic                                          sel_resp_vld,
  input  logic                                          sel_resp_rdy,
  input  logic [ADDR_WIDTH+NUM_PARTITIONS-1:0]          rd_req_data,
  input  logic                                          rd_req_vld,
  output logic                                          rd_req_rdy,
  output logic [DATA_WIDTH-1:0]                         rd_resp_data,
  output logic                                          rd_resp_vld,
  input  logic                                          rd_resp_rdy,
  input  logic [DATA_WIDTH+ADDR_WIDTH+NUM_PARTITIONS-1:0] wr_req_data,
  input  logic                                          wr_req_vld,
  output logic                                          wr_req_rdy,
  output logic                                          wr_resp_vld,
  input  logic                                          wr_resp_rdy,
  output logic [NUM_RAMS*ADDR_WIDTH-1:0]                ram_rd_addr,
  output logic [NUM_RAMS*NUM_PARTITIONS-1:0]            ram_rd_mask,
  output logic [NUM_RAMS-1:0]                           ram_rd_en,
  input  logic [NUM_RAMS*DATA_WIDTH-1:0]                ram_rd_data,
  output logic [NUM_RAMS*ADDR_WIDTH-1:0]                ram_wr_addr,
  output logic [NUM_RAMS*DATA_WIDTH-1:0]                ram_wr_data,
  output logic [NUM_RAMS*NUM_PARTITIONS-1:0]            ram_wr_mask,
  output logic [NUM_RAMS-1:0]                           ram_wr_en
);

  typedef enum logic [1:0] {IDLE, DRAIN, SEL_RESP} state_t;

  state_t                  state;
  logic [SEL_WIDTH-1:0]    sel;
  logic [SEL_WIDTH-1:0]    sel_pend;
  logic [SEL_WIDTH-1:0]    rd_sel;
  logic                    rd_inflight;
  logic [DATA_WIDTH-1:0]   fifo_mem [2];
  logic                    fifo_wptr;
  logic                    fifo_rptr;
  logic [1:0]              fifo_cnt;
  logic [DATA_WIDTH-1:0]   rd_ram_data;
  logic                    rd_fire;
  logic                    wr_fire;
  logic                    sel_fire;
  logic                    rd_pop;
  logic [1:0]              rd_used;

  logic [NUM_PARTITIONS-1:0] rd_mask;
  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [NUM_PARTITIONS-1:0] wr_mask;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;

  assign rd_mask = rd_req_data[NUM_PARTITIONS-1:0];
  assign rd_addr = rd_req_data[NUM_PARTITIONS +: ADDR_WIDTH];
  assign wr_mask = wr_req_data[NUM_PARTITIONS-1:0];
  assign wr_addr = wr_req_data[NUM_PARTITIONS +: ADDR_WIDTH];
  assign wr_data = wr_req_data[NUM_PARTITIONS+ADDR_WIDTH +: DATA_WIDTH];

  assign ram_rd_addr = {NUM_RAMS{rd_addr}};
  assign ram_rd_mask = {NUM_RAMS{rd_mask}};
  assign ram_wr_addr = {NUM_RAMS{wr_addr}};
  assign ram_wr_data = {NUM_RAMS{wr_data}};
  assign ram_wr_mask = {NUM_RAMS{wr_mask}};

  assign rd_resp_vld  = (fifo_cnt != 2'd0);
  assign rd_resp_data = fifo_mem[fifo_rptr];
  assign rd_pop       = rd_resp_vld && rd_resp_rdy;
  assign rd_used      = fifo_cnt + {1'b0, rd_inflight};

  // A pop in the same cycle frees a slot, so streaming reads never bubble.
  assign rd_req_rdy   = !rst && (state == IDLE) && ((rd_used - {1'b0, rd_pop}) < 2'd2);
  assign wr_req_rdy   = !rst && (state == IDLE) && (!wr_resp_vld || wr_resp_rdy);
  assign sel_req_rdy  = !rst && (state == IDLE);
  assign sel_resp_vld = (state == SEL_RESP);

  assign rd_fire  = rd_req_vld && rd_req_rdy;
  assign wr_fire  = wr_req_vld && wr_req_rdy;
  assign sel_fire = sel_req_vld && sel_req_rdy;

  always_comb begin
    ram_rd_en   = '0;
    ram_wr_en   = '0;
    rd_ram_data = '0;
    for (int i = 0; i < NUM_RAMS; i++) begin
      ram_rd_en[i] = rd_fire && (int'(sel) == i);
      ram_wr_en[i] = wr_fire && (int'(sel) == i);
      if (int'(rd_sel) == i) rd_ram_data = ram_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_inflight) fifo_mem[fifo_wptr] <= rd_ram_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      sel_pend    <= '0;
      rd_sel      <= '0;
      rd_inflight <= 1'b0;
      fifo_wptr   <= 1'b0;
      fifo_rptr   <= 1'b0;
      fifo_cnt    <= 2'd0;
      wr_resp_vld <= 1'b0;
    end else begin
      rd_inflight <= rd_fire;
      if (rd_fire) rd_sel <= sel;
      if (rd_inflight) fifo_wptr <= ~fifo_wptr;
      if (rd_pop) fifo_rptr <= ~fifo_rptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, rd_pop};

      if (wr_fire) wr_resp_vld <= 1'b1;
      else if (wr_resp_rdy) wr_resp_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (sel_fire) begin
            state    <= DRAIN;
            sel_pend <= sel_req_data;
          end
        end
        DRAIN: begin
          // Out-of-range selections still complete the handshake but keep the old RAM.
          if (!rd_inflight && (fifo_cnt == 2'd0) && !wr_resp_vld) begin
            state <= SEL_RESP;
            if (int'(sel_pend) < NUM_RAMS) sel <= sel_pend;
          end
        end
        SEL_RESP: begin
          if (sel_resp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_demux_n.sv
// Bench for ram_demux_n: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue/array reference model and bench-side RAMs.
module tb_ram_demux_n;
  localparam int DW = 64;
  localparam int SZ = 128;
  localparam int AW = 7;
  localparam int NP = 64;
  localparam int NR = 4;
  localparam int SW = 3;

  logic clk;
  logic rst;
  logic [SW-1:0] sel_req_data;
  logic sel_req_vld, sel_req_rdy, sel_resp_vld, sel_resp_rdy;
  logic [AW+NP-1:0] rd_req_data;
  logic rd_req_vld, rd_req_rdy;
  logic [DW-1:0] rd_resp_data;
  logic rd_resp_vld, rd_resp_rdy;
  logic [DW+AW+NP-1:0] wr_req_data;
  logic wr_req_vld, wr_req_rdy, wr_resp_vld, wr_resp_rdy;
  logic [NR*AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [NR*NP-1:0] ram_rd_mask, ram_wr_mask;
  logic [NR-1:0] ram_rd_en, ram_wr_en;
  logic [NR*DW-1:0] ram_rd_data, ram_wr_data;

  ram_demux_n #(.DATA_WIDTH(DW), .SIZE(SZ), .ADDR_WIDTH(AW), .NUM_PARTITIONS(NP),
                .NUM_RAMS(NR), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .sel_req_data(sel_req_data), .sel_req_vld(sel_req_vld), .sel_req_rdy(sel_req_rdy),
    .sel_resp_vld(sel_resp_vld), .sel_resp_rdy(sel_resp_rdy),
    .rd_req_data(rd_req_data), .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
    .rd_resp_data(rd_resp_data), .rd_resp_vld(rd_resp_vld), .rd_resp_rdy(rd_resp_rdy),
    .wr_req_data(wr_req_data), .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy),
    .wr_resp_vld(wr_resp_vld), .wr_resp_rdy(wr_resp_rdy),
    .ram_rd_addr(ram_rd_addr), .ram_rd_mask(ram_rd_mask), .ram_rd_en(ram_rd_en),
    .ram_rd_data(ram_rd_data),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_mask(ram_wr_mask),
    .ram_wr_en(ram_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bench-side RAMs: one-cycle read latency, masked-off bits read as 0, read returns old data.
  logic [DW-1:0] ram [NR][SZ];
  bit ram_init = 0;
  logic [AW-1:0] ra, wa;
  logic [DW-1:0] rm, wm;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < NR; i++) for (int j = 0; j < SZ; j++) ram[i][j] = '0;
      ram_init = 1;
    end
    for (int i = 0; i < NR; i++) begin
      ra = ram_rd_addr[i*AW +: AW];
      rm = ram_rd_mask[i*NP +: NP];
      if (ram_rd_en[i]) ram_rd_data[i*DW +: DW] <= ram[i][ra] & rm;
      else ram_rd_data[i*DW +: DW] <= {$urandom, $urandom};
      wa = ram_wr_addr[i*AW +: AW];
      wm = ram_wr_mask[i*NP +: NP];
      if (ram_wr_en[i]) ram[i][wa] = (ram[i][wa] & ~wm) | (ram_wr_data[i*DW +: DW] & wm);
    end
  end

  // Reference model: outstanding reads as a queue of expected data with the cycle they appear.
  typedef struct { logic [DW-1:0] d; int vis; } rsp_t;
  rsp_t exp_q[$];
  logic [DW-1:0] gold [NR][SZ];
  bit gold_init = 0;
  bit armed = 0;
  int phase = 0;      // 0 accepting, 1 waiting for drain, 2 answering select
  int m_sel = 0;
  int m_pend = 0;
  bit m_wr_pend = 0;
  int cyc = 0;
  bit e_rsp_vld, e_pop, e_sel_rdy, e_rd_rdy, e_wr_rdy, e_rd_fire, e_wr_fire, e_sel_fire, drained;
  int occ;
  logic [NR-1:0] e_onehot;
  logic [AW-1:0] q_ra, q_wa;
  logic [NP-1:0] q_rm, q_wm;
  logic [DW-1:0] q_wd;

  always @(negedge clk) begin
    if (!gold_init) begin
      for (int i = 0; i < NR; i++) for (int j = 0; j < SZ; j++) gold[i][j] = '0;
      gold_init = 1;
    end
    q_rm = rd_req_data[NP-1:0];
    q_ra = rd_req_data[NP +: AW];
    q_wm = wr_req_data[NP-1:0];
    q_wa = wr_req_data[NP +: AW];
    q_wd = wr_req_data[NP+AW +: DW];
    e_pop = 0; e_rd_fire = 0; e_wr_fire = 0; e_sel_fire = 0;
    if (armed) begin
      e_rsp_vld = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
      e_pop     = e_rsp_vld && rd_resp_rdy;
      occ       = exp_q.size() - (e_pop ? 1 : 0);
      e_sel_rdy = !rst && (phase == 0);
      e_rd_rdy  = e_sel_rdy && (occ < 2);
      e_wr_rdy  = e_sel_rdy && (!m_wr_pend || wr_resp_rdy);
      e_rd_fire = rd_req_vld && e_rd_rdy;
      e_wr_fire = wr_req_vld && e_wr_rdy;
      e_sel_fire = sel_req_vld && e_sel_rdy;
      e_onehot  = NR'(1) << m_sel;
      chk("sel_req_rdy", sel_req_rdy, e_sel_rdy);
      chk("sel_resp_vld", sel_resp_vld, phase == 2);
      chk("rd_req_rdy", rd_req_rdy, e_rd_rdy);
      chk("wr_req_rdy", wr_req_rdy, e_wr_rdy);
      chk("wr_resp_vld", wr_resp_vld, m_wr_pend);
      chk("rd_resp_vld", rd_resp_vld, e_rsp_vld);
      if (e_rsp_vld) chk("rd_resp_data", rd_resp_data, exp_q[0].d);
      chk("ram_rd_en", ram_rd_en, e_rd_fire ? e_onehot : '0);
      chk("ram_wr_en", ram_wr_en, e_wr_fire ? e_onehot : '0);
      if (e_rd_fire)
        chk("rd_bcast", (ram_rd_addr == {NR{q_ra}}) && (ram_rd_mask == {NR{q_rm}}), 1);
      if (e_wr_fire)
        chk("wr_bcast", (ram_wr_addr == {NR{q_wa}}) && (ram_wr_mask == {NR{q_wm}}) &&
                        (ram_wr_data == {NR{q_wd}}), 1);
    end
    if (rst) begin
      exp_q.delete();
      phase = 0; m_sel = 0; m_wr_pend = 0; armed = 1;
    end else if (armed) begin
      drained = (phase == 1) && (exp_q.size() == 0) && !m_wr_pend;
      if (e_pop) void'(exp_q.pop_front());
      if (e_rd_fire) exp_q.push_back('{gold[m_sel][q_ra] & q_rm, cyc + 2});
      if (e_wr_fire) gold[m_sel][q_wa] = (gold[m_sel][q_wa] & ~q_wm) | (q_wd & q_wm);
      if (e_wr_fire) m_wr_pend = 1;
      else if (wr_resp_rdy) m_wr_pend = 0;
      if (phase == 0 && e_sel_fire) begin
        phase = 1;
        m_pend = int'(sel_req_data);
      end else if (drained) begin
        phase = 2;
        if (m_pend < NR) m_sel = m_pend;
      end else if (phase == 2 && sel_resp_rdy) begin
        phase = 0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!(which == 0 ? sel_resp_vld : sel_req_rdy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, (which == 0 ? sel_resp_vld : sel_req_rdy), 1);
  endtask

  localparam logic [NP-1:0] ALL = {NP{1'b1}};

  initial begin
    rst = 1; sel_req_vld = 0; sel_req_data = '0; sel_resp_rdy = 1;
    rd_req_vld = 0; rd_req_data = '0; rd_resp_rdy = 1;
    wr_req_vld = 0; wr_req_data = '0; wr_resp_rdy = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rdy_in_reset", {sel_req_rdy, rd_req_rdy, wr_req_rdy}, 0);
    tick(); rst = 0;
    @(negedge clk);
    chk("reset_sel_rdy", sel_req_rdy, 1);
    chk("reset_vlds", {rd_resp_vld, wr_resp_vld, sel_resp_vld}, 0);

    // write then read RAM 0
    tick(); wr_req_vld = 1; wr_req_data = {64'hA5A5, 7'd3, ALL};
    @(negedge clk); chk("a_wr_en", ram_wr_en, 4'b0001);
    tick(); wr_req_vld = 0; rd_req_vld = 1; rd_req_data = {7'd3, ALL};
    @(negedge clk); chk("a_rd_en", ram_rd_en, 4'b0001); chk("a_wr_resp", wr_resp_vld, 1);
    tick(); rd_req_vld = 0;
    @(negedge clk); chk("a_rd_latency", rd_resp_vld, 0); chk("a_wr_resp_done", wr_resp_vld, 0);
    tick();
    @(negedge clk); chk("a_rd_vld", rd_resp_vld, 1); chk("a_rd_data", rd_resp_data, 64'hA5A5);
    tick();
    @(negedge clk); chk("a_one_resp", rd_resp_vld, 0);

    // switch to RAM 2 with a read outstanding
    tick(); rd_resp_rdy = 0; rd_req_vld = 1; rd_req_data = {7'd3, ALL};
    @(negedge clk); chk("b_rd_en", ram_rd_en, 4'b0001);
    tick(); rd_req_vld = 0; sel_req_vld = 1; sel_req_data = 3'd2; sel_resp_rdy = 0;
    @(negedge clk); chk("b_sel_rdy", sel_req_rdy, 1);
    tick(); sel_req_vld = 0;
    repeat (4) begin
      @(negedge clk);
      chk("b_sel_resp_held", sel_resp_vld, 0);
      chk("b_no_rd_in_drain", rd_req_rdy, 0);
      tick();
    end
    rd_resp_rdy = 1;
    wait_for(0, "b_sel_resp_seen");
    tick(); sel_resp_rdy = 1;
    tick(); wr_req_vld = 1; wr_req_data = {64'h5555, 7'd5, ALL};
    @(negedge clk); chk("b_wr_en_ram2", ram_wr_en, 4'b0100);

    // backpressure: third read blocked, in-order release
    tick(); wr_req_data = {64'h1111, 7'd10, ALL};
    tick(); wr_req_data = {64'h2222, 7'd11, ALL};
    tick(); wr_req_vld = 0; rd_resp_rdy = 0; rd_req_vld = 1; rd_req_data = {7'd10, ALL};
    @(negedge clk); chk("c_acc1", rd_req_rdy, 1);
    tick(); rd_req_data = {7'd11, ALL};
    @(negedge clk); chk("c_acc2", rd_req_rdy, 1);
    tick(); rd_req_data = {7'd12, ALL};
    @(negedge clk); chk("c_third_blocked", rd_req_rdy, 0);
    tick(); rd_req_vld = 0; rd_resp_rdy = 1;
    @(negedge clk); chk("c_vld1", rd_resp_vld, 1); chk("c_data1", rd_resp_data, 64'h1111);
    tick();
    @(negedge clk); chk("c_vld2", rd_resp_vld, 1); chk("c_data2", rd_resp_data, 64'h2222);
    tick();
    @(negedge clk); chk("c_empty", rd_resp_vld, 0);

    // out-of-range select keeps RAM 2
    tick(); sel_req_vld = 1; sel_req_data = 3'd5;
    @(negedge clk);
    tick(); sel_req_vld = 0;
    wait_for(0, "d_sel_resp");
    wait_for(1, "d_back_idle");
    tick(); rd_req_vld = 1; rd_req_data = {7'd10, ALL};
    @(negedge clk); chk("d_rd_en_ram2", ram_rd_en, 4'b0100);
    tick(); rd_req_vld = 0;
    tick();
    @(negedge clk); chk("d_rd_data", rd_resp_data, 64'h1111);

    // simultaneous read, write and select from reset
    tick(); rst = 1;
    tick(); rst = 0;
    rd_req_vld = 1; rd_req_data = {7'd3, ALL};
    wr_req_vld = 1; wr_req_data = {64'h77, 7'd20, ALL};
    sel_req_vld = 1; sel_req_data = 3'd1;
    @(negedge clk);
    chk("e_rd_en", ram_rd_en, 4'b0001); chk("e_wr_en", ram_wr_en, 4'b0001);
    chk("e_sel_rdy", sel_req_rdy, 1);
    tick(); rd_req_vld = 0; wr_req_vld = 0; sel_req_vld = 0;
    @(negedge clk); chk("e_drain", sel_resp_vld, 0);
    wait_for(0, "e_sel_resp");
    wait_for(1, "e_back_idle");
    tick(); wr_req_vld = 1; wr_req_data = {64'h88, 7'd21, ALL};
    @(negedge clk); chk("e_wr_en_ram1", ram_wr_en, 4'b0010);
    tick(); wr_req_vld = 0;

    // reset with a read outstanding
    rd_resp_rdy = 0; rd_req_vld = 1; rd_req_data = {7'd3, ALL};
    @(negedge clk);
    tick(); rd_req_vld = 0; rst = 1;
    @(negedge clk); chk("f_rdy_in_rst", {sel_req_rdy, rd_req_rdy, wr_req_rdy}, 0);
    tick(); rst = 0;
    @(negedge clk); chk("f_rsp_dropped", rd_resp_vld, 0); chk("f_rd_rdy", rd_req_rdy, 1);
    tick(); rd_resp_rdy = 1; rd_req_vld = 1; rd_req_data = {7'd3, ALL};
    @(negedge clk); chk("f_rd_en_ram0", ram_rd_en, 4'b0001);
    tick(); rd_req_vld = 0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst          = ($urandom_range(0, 199) == 0);
      sel_req_vld  = ($urandom_range(0, 15) == 0);
      sel_req_data = SW'($urandom_range(0, 5));
      sel_resp_rdy = ($urandom_range(0, 3) != 0);
      rd_req_vld   = $urandom_range(0, 1) == 1;
      rd_req_data  = {AW'($urandom_range(0, 7)),
                      ($urandom_range(0, 1) == 1) ? ALL : NP'({$urandom, $urandom})};
      rd_resp_rdy  = ($urandom_range(0, 3) != 0);
      wr_req_vld   = $urandom_range(0, 1) == 1;
      wr_req_data  = {DW'({$urandom, $urandom}), AW'($urandom_range(0, 7)),
                      ($urandom_range(0, 1) == 1) ? ALL : NP'({$urandom, $urandom})};
      wr_resp_rdy  = ($urandom_range(0, 3) != 0);
    end
    tick();
    rst = 0; sel_req_vld = 0; rd_req_vld = 0; wr_req_vld = 0;
    rd_resp_rdy = 1; wr_resp_rdy = 1; sel_resp_rdy = 1;
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
